// File: rtl/alu_seq.sv
// Multi-cycle ALU sequencer: one EXEC cycle per op, or N cycles for shift/rotate, then DONE.
// Latency: done_valid one cycle after the last EXEC cycle; DONE holds until done_ready, req_ready only in IDLE.
module alu_seq #(
    parameter int SHW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [3:0]     req_op,
    input  logic [SHW-1:0] req_cnt,
    input  logic           req_cin,
    output logic [5:0]     alu_ctrl,
    output logic           alu_c_flag,
    output logic           alu_src_sel,
    output logic           alu_res_we,
    input  logic           alu_c_out,
    output logic           done_valid,
    input  logic           done_ready,
    output logic           done_c,
    output logic           err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_ILLEGAL = 4'd15;

    state_t         state_q, state_d;
    logic [3:0]     op_q, op_d;
    logic [SHW-1:0] rem_q, rem_d;
    logic           first_q, first_d;
    logic           carry_q, carry_d;
    logic           mov_q, mov_d;
    logic           err_q, err_d;

    function automatic logic is_shift(input logic [3:0] op);
        return (op >= 4'd9) && (op <= 4'd14);
    endfunction

    function automatic logic [5:0] ctrl_of(input logic [3:0] op);
        logic [5:0] c;
        case (op)
            4'd0:    c = 6'b000000;
            4'd1:    c = 6'b010010;
            4'd2:    c = 6'b100010;
            4'd3:    c = 6'b011000;
            4'd4:    c = 6'b010100;
            4'd5:    c = 6'b011100;
            4'd6:    c = 6'b001100;
            4'd7:    c = 6'b110110;
            4'd8:    c = 6'b000110;
            4'd9:    c = 6'b000001;
            4'd10:   c = 6'b001001;
            4'd11:   c = 6'b000101;
            4'd12:   c = 6'b001101;
            4'd13:   c = 6'b010001;
            4'd14:   c = 6'b010101;
            default: c = 6'b000000;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= 4'd0;
            rem_q   <= '0;
            first_q <= 1'b0;
            carry_q <= 1'b0;
            mov_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            carry_q <= carry_d;
            mov_q   <= mov_d;
            err_q   <= err_d;
        end
    end

    // carry_q holds the request carry until the first EXEC edge, then the ALU carry of the
    // previous EXEC cycle; it therefore serves both as alu_c_flag and as the final done_c.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rem_d       = rem_q;
        first_d     = first_q;
        carry_d     = carry_q;
        mov_d       = mov_q;
        err_d       = err_q;
        req_ready   = 1'b0;
        alu_ctrl    = 6'b000000;
        alu_c_flag  = 1'b0;
        alu_src_sel = 1'b0;
        alu_res_we  = 1'b0;
        done_valid  = 1'b0;
        done_c      = 1'b0;
        err         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op;
                    first_d = 1'b1;
                    carry_d = req_cin;
                    mov_d   = is_shift(req_op) && (req_cnt == '0);
                    if (req_op == OP_ILLEGAL) begin
                        err_d   = 1'b1;
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        rem_d   = (is_shift(req_op) && (req_cnt != '0)) ? req_cnt : SHW'(1);
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                alu_ctrl    = mov_q ? 6'b000000 : ctrl_of(op_q);
                alu_c_flag  = carry_q;
                alu_src_sel = ~first_q;
                alu_res_we  = 1'b1;
                carry_d     = alu_c_out;
                first_d     = 1'b0;
                rem_d       = rem_q - SHW'(1);
                if (rem_q == SHW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_valid = 1'b1;
                done_c     = carry_q;
                err        = err_q;
                if (done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq; a small ALU-side model supplies alu_c_out and tracks the expected carry.
module tb_alu_seq;
    localparam int SHW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [3:0]     req_op = 4'd0;
    logic [SHW-1:0] req_cnt = '0;
    logic           req_cin = 1'b0;
    logic [5:0]     alu_ctrl;
    logic           alu_c_flag;
    logic           alu_src_sel;
    logic           alu_res_we;
    logic           alu_c_out = 1'b0;
    logic           done_valid;
    logic           done_ready = 1'b0;
    logic           done_c;
    logic           err;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.SHW(SHW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_cnt    (req_cnt),
        .req_cin    (req_cin),
        .alu_ctrl   (alu_ctrl),
        .alu_c_flag (alu_c_flag),
        .alu_src_sel(alu_src_sel),
        .alu_res_we (alu_res_we),
        .alu_c_out  (alu_c_out),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_c     (done_c),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] ref_ctrl(input logic [3:0] op);
        logic [5:0] table_v [16];
        table_v = '{6'b000000, 6'b010010, 6'b100010, 6'b011000, 6'b010100, 6'b011100,
                    6'b001100, 6'b110110, 6'b000110, 6'b000001, 6'b001001, 6'b000101,
                    6'b001101, 6'b010001, 6'b010101, 6'b000000};
        return table_v[op];
    endfunction

    function automatic bit ref_is_shift(input logic [3:0] op);
        return (op >= 4'd9) && (op <= 4'd14);
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, req_ready, 1);
        chk({tag, "_dvld"}, done_valid, 0);
        chk({tag, "_ctrl"}, alu_ctrl, 0);
        chk({tag, "_we"}, alu_res_we, 0);
        chk({tag, "_src"}, alu_src_sel, 0);
        chk({tag, "_cflag"}, alu_c_flag, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_donec"}, done_c, 0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [3:0] op, input logic [SHW-1:0] cnt, input logic cin,
                          input int wait_n, input logic [15:0] cseq);
        int         m;
        logic       carry;
        logic       c;
        logic [5:0] ectl;
        m     = (op == 4'd15) ? 0 : ((ref_is_shift(op) && cnt != 0) ? int'(cnt) : 1);
        ectl  = (ref_is_shift(op) && cnt == 0) ? 6'b000000 : ref_ctrl(op);
        carry = cin;

        chk("acc_ready", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_cnt   = cnt;
        req_cin   = cin;
        @(negedge clk);
        // noise on the request bus while busy must not disturb the operation
        req_valid = 1'($urandom);
        req_op    = 4'($urandom);
        req_cnt   = SHW'($urandom);
        req_cin   = 1'($urandom);

        for (int i = 0; i < m; i++) begin
            chk("exec_ctrl", alu_ctrl, ectl);
            chk("exec_we", alu_res_we, 1);
            chk("exec_src", alu_src_sel, (i != 0) ? 1 : 0);
            chk("exec_cflag", alu_c_flag, carry);
            chk("exec_ready", req_ready, 0);
            chk("exec_dvld", done_valid, 0);
            // a MOV passes the carry through unchanged
            c         = (ectl == 6'b000000) ? carry : cseq[i];
            alu_c_out = c;
            carry     = c;
            @(negedge clk);
        end

        alu_c_out = 1'($urandom);
        for (int w = 0; w <= wait_n; w++) begin
            chk("done_vld", done_valid, 1);
            chk("done_c", done_c, carry);
            chk("done_err", err, (op == 4'd15) ? 1 : 0);
            chk("done_ready_lo", req_ready, 0);
            chk("done_ctrl", alu_ctrl, 0);
            chk("done_we", alu_res_we, 0);
            chk("done_src", alu_src_sel, 0);
            done_ready = (w == wait_n);
            @(negedge clk);
        end
        done_ready = 1'b0;
        req_valid  = 1'b0;
        chk_idle("post");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]     rop;
        logic [SHW-1:0] rcnt;

        // power-on reset
        repeat (2) @(negedge clk);
        chk_idle("rst0");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("idle0");

        run_op(4'd1, 4'd0, 1'b0, 0, 16'h0000);        // ADD
        run_op(4'd13, 4'd3, 1'b1, 0, 16'b110);         // ROL, carries 0,1,1
        run_op(4'd12, 4'd0, 1'b1, 0, 16'hFFFF);        // SRA count 0, carry preserved
        run_op(4'd12, 4'd0, 1'b0, 1, 16'hFFFF);
        run_op(4'd15, 4'd7, 1'b1, 0, 16'h0000);        // illegal
        run_op(4'd2, 4'd5, 1'b1, 5, 16'h0000);         // SUB, consumer stalls 5 cycles
        run_op(4'd9, 4'd15, 1'b0, 0, 16'hA5A5);        // full-length shift

        // async reset during the second EXEC cycle of SLL cnt=15
        req_valid = 1'b1;
        req_op    = 4'd9;
        req_cnt   = 4'd15;
        req_cin   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        alu_c_out = 1'b0;
        chk("rstx_exec1_we", alu_res_we, 1);
        @(negedge clk);
        chk("rstx_exec2_src", alu_src_sel, 1);
        #2 rst = 1'b1;
        #1 chk_idle("rstx");
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rstx_no_done", done_valid, 0);
            chk("rstx_ready", req_ready, 1);
        end
        run_op(4'd5, 4'd0, 1'b1, 0, 16'h0000);         // XOR after reset

        for (int t = 0; t < 40; t++) begin
            rop  = 4'($urandom_range(0, 15));
            rcnt = SHW'($urandom_range(0, 15));
            run_op(rop, rcnt, 1'($urandom), int'($urandom_range(0, 3)), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
